// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and index helpers for the round-robin burst arbiter.
package rr_burst_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_rr_pick.sv
// Rotating priority picker: first requester at or after ptr, wrapping past N-1.
module rr_burst_arbiter_rr_pick
  import rr_burst_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_req_valid,
  input  logic [SW-1:0] i_ptr,
  output logic          o_any,
  output logic [SW-1:0] o_idx
);

  int w_pos;

  // Scan from the farthest slot back toward ptr so the nearest requester wins.
  always_comb begin
    o_any = |i_req_valid;
    o_idx = '0;
    w_pos = 32'sd0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      w_pos = (w_pos >= N) ? w_pos - N : w_pos;
      o_idx = i_req_valid[w_pos[SW-1:0]] ? SW'(w_pos) : o_idx;
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting bursts of up to MAX_BURST beats from N senders
// onto one registered output stage with downstream backpressure.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int W         = 4,
  parameter  int MAX_BURST = 4,
  localparam int SW        = idx_w(N)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req_valid,
  input  logic [N*W-1:0] i_req_data,
  output logic [N-1:0]   o_req_ready,
  output logic           o_out_en,
  output logic [W-1:0]   o_out_data,
  output logic [SW-1:0]  o_out_src,
  input  logic           i_out_ready,
  output logic           o_busy
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e    r_state;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_owner;
  logic [CW-1:0] r_beat_cnt;
  logic          r_out_en;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_src;

  logic          w_any;
  logic [SW-1:0] w_pick;
  logic          w_load;
  logic          w_owner_valid;
  logic          w_xfer;
  logic          w_last;
  logic [W-1:0]  w_owner_data;
  logic [SW-1:0] w_next_ptr;

  rr_burst_arbiter_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .i_req_valid (i_req_valid),
    .i_ptr       (r_ptr),
    .o_any       (w_any),
    .o_idx       (w_pick)
  );

  // The output register can take a new beat when empty or being drained.
  assign w_load        = ~r_out_en | i_out_ready;
  assign w_owner_valid = i_req_valid[r_owner];
  assign w_xfer        = (r_state == ARB_GRANT) & w_owner_valid & w_load;
  assign w_last        = (r_beat_cnt == LAST_BEAT);
  assign w_owner_data  = i_req_data[r_owner*W +: W];
  assign w_next_ptr    = SW'(wrap_inc(int'(r_owner), N));

  assign o_out_en   = r_out_en;
  assign o_out_data = r_out_data;
  assign o_out_src  = r_out_src;
  assign o_busy     = (r_state == ARB_GRANT);

  always_comb begin
    o_req_ready = '0;
    if (r_state == ARB_GRANT) begin
      o_req_ready[r_owner] = w_load;
    end else begin
      o_req_ready = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_out_en   <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else begin
      if (w_load) begin
        r_out_en <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_owner_data;
          r_out_src  <= r_owner;
        end
      end
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // Release on a full burst or when the owner has nothing to send.
          if ((w_xfer && w_last) || !w_owner_valid) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= w_next_ptr;
            r_beat_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural arbiter model.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MB = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_en;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;
  logic           busy;

  always #5 clk = ~clk;

  rr_burst_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_out_en    (out_en),
    .o_out_data  (out_data),
    .o_out_src   (out_src),
    .i_out_ready (out_ready),
    .o_busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] d [N];        // next value each sender will offer
  logic [W-1:0] rx_next [N];  // next value the receiver expects per source

  // model state: who holds the grant, rotation pointer, beats taken, output stage
  bit m_grant;
  int m_ptr, m_owner, m_beats;
  bit m_out_en;
  int m_out_data, m_out_src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] v;
    v = '0;
    if (m_grant && (!m_out_en || out_ready)) v[m_owner] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    bit load, xfer, found;
    logic [N-1:0] acc;
    acc = rst ? '0 : (req_valid & m_ready());
    if (rst) begin
      m_grant = 0; m_ptr = 0; m_owner = 0; m_beats = 0;
      m_out_en = 0; m_out_data = 0; m_out_src = 0;
      for (int i = 0; i < N; i++) rx_next[i] = d[i];
    end else begin
      load = !m_out_en || out_ready;
      xfer = m_grant && req_valid[m_owner] && load;
      if (load) begin
        m_out_en = xfer;
        if (xfer) begin
          m_out_data = int'(d[m_owner]);
          m_out_src  = m_owner;
        end
      end
      if (!m_grant) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1; m_owner = (m_ptr + k) % N; m_grant = 1; m_beats = 0;
          end
        end
      end else if (xfer) begin
        m_beats++;
        if (m_beats == MB) begin m_grant = 0; m_ptr = (m_owner + 1) % N; end
      end else if (!req_valid[m_owner]) begin
        m_grant = 0; m_ptr = (m_owner + 1) % N;
      end
      for (int i = 0; i < N; i++) if (acc[i]) d[i] = d[i] + 4'd1;
    end
  endtask

  task automatic compare_all();
    chk("out_en", 32'(out_en), 32'(m_out_en));
    if (m_out_en) begin
      chk("out_data", 32'(out_data), 32'(m_out_data));
      chk("out_src", 32'(out_src), 32'(m_out_src));
    end
    chk("busy", 32'(busy), 32'(m_grant));
    chk("req_ready", 32'(req_ready), 32'(m_ready()));
    if (out_en === 1'b1 && out_ready === 1'b1 && !$isunknown(out_src)) begin
      chk("rx_seq", 32'(out_data), 32'(rx_next[out_src]));
      rx_next[out_src] = rx_next[out_src] + 4'd1;
    end
  endtask

  // One clock: update model from the inputs sampled at this edge, drive new inputs, compare.
  task automatic cyc(input bit r, input logic [N-1:0] v, input bit ordy);
    @(posedge clk);
    model_step();
    if (rst) cmp_en = 1'b1;
    #1;
    rst = r; req_valid = v; out_ready = ordy;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = d[i];
    @(negedge clk);
    if (cmp_en) compare_all();
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < N; i++) d[i] = 4'd1;
  endtask

  int src_seq[$];
  logic [N-1:0] rv;
  bit found_en;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin d[i] = 4'd1; rx_next[i] = 4'd1; end

    // reset state
    do_reset();
    chk("rst_out_en", 32'(out_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data_src", 32'({out_src, out_data}), 32'd0);

    // 1: lone sender 1, three beats, then pointer moves to 2
    cyc(1'b0, 4'b0010, 1'b1);
    chk("t1_idle_ready", 32'(req_ready), 32'd0);
    cyc(1'b0, 4'b0010, 1'b1);
    chk("t1_ready", 32'(req_ready), 32'b0010);
    cyc(1'b0, 4'b0010, 1'b1);
    chk("t1_beat1", 32'({out_en, out_src, out_data}), 32'({1'b1, 2'd1, 4'd1}));
    cyc(1'b0, 4'b0010, 1'b1);
    chk("t1_beat2", 32'({out_en, out_src, out_data}), 32'({1'b1, 2'd1, 4'd2}));
    cyc(1'b0, 4'b0000, 1'b1);
    chk("t1_beat3", 32'({out_en, out_src, out_data}), 32'({1'b1, 2'd1, 4'd3}));
    cyc(1'b0, 4'b1111, 1'b1);
    chk("t1_drain", 32'({out_en, busy}), 32'd0);
    cyc(1'b0, 4'b1111, 1'b1);
    chk("t1_ptr2", 32'(req_ready), 32'b0100);

    // 2: all senders valid, bursts of four in rotation
    do_reset();
    for (int c = 0; c < 22; c++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      if (out_en === 1'b1) src_seq.push_back(int'(out_src));
    end
    chk("t2_count", 32'(src_seq.size() >= 16), 32'd1);
    for (int k = 0; k < 16 && k < src_seq.size(); k++) chk("t2_src", 32'(src_seq[k]), 32'(k / 4));

    // 3: backpressure holds the output and blocks acceptance
    found_en = 0;
    for (int c = 0; c < 10 && !found_en; c++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      found_en = (out_en === 1'b1);
    end
    chk("t3_found", 32'(found_en), 32'd1);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 4'b1111, 1'b0);
      chk("t3_hold_en", 32'(out_en), 32'd1);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    for (int c = 0; c < 8; c++) cyc(1'b0, 4'b1111, 1'b1);

    // 4: owner 2 drops after two beats while 3 rises
    do_reset();
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b1000, 1'b1);
    chk("t4_busy", 32'(busy), 32'd1);
    cyc(1'b0, 4'b1001, 1'b1);
    chk("t4_released", 32'(busy), 32'd0);
    cyc(1'b0, 4'b1001, 1'b1);
    chk("t4_grant3", 32'(req_ready), 32'b1000);

    // 5: reset mid-burst of sender 1
    do_reset();
    cyc(1'b0, 4'b0010, 1'b1);
    cyc(1'b0, 4'b0010, 1'b1);
    cyc(1'b0, 4'b0010, 1'b1);
    cyc(1'b1, 4'b0010, 1'b1);
    chk("t5_beat2", 32'({out_en, out_src, out_data}), 32'({1'b1, 2'd1, 4'd2}));
    cyc(1'b0, 4'b1111, 1'b1);
    chk("t5_cleared", 32'({out_en, busy, req_ready}), 32'd0);
    cyc(1'b0, 4'b1111, 1'b1);
    chk("t5_grant0", 32'(req_ready), 32'b0001);

    // 6: owner 3 full burst, pointer wraps to 0
    do_reset();
    cyc(1'b0, 4'b1000, 1'b1);
    for (int c = 0; c < 4; c++) cyc(1'b0, 4'b1101, 1'b1);
    chk("t6_busy", 32'(busy), 32'd1);
    cyc(1'b0, 4'b0101, 1'b1);
    chk("t6_released", 32'(busy), 32'd0);
    cyc(1'b0, 4'b0101, 1'b1);
    chk("t6_grant0", 32'(req_ready), 32'b0001);

    // randomized traffic with backpressure and occasional reset
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        rv[i] = rv[i] ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
      cyc($urandom_range(299) == 0, rv, $urandom_range(3) != 0);
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
